// File: rtl/pifo_stfq_ranker_if.sv
// Enqueue-side bus of the STFQ ranker: two arrival lanes, the two push lanes
// into the PIFO scheduler, and the scheduler's dequeue strobe.
interface pifo_stfq_ranker_if #(
  parameter int FLOWS = 10
);
  logic             in_valid_1;
  logic             in_valid_2;
  logic             in_ready_1;
  logic             in_ready_2;
  logic [FLOWS-1:0] in_flow_1;
  logic [FLOWS-1:0] in_flow_2;
  logic [15:0]      in_len_1;
  logic [15:0]      in_len_2;
  logic [31:0]      in_value_1;
  logic [31:0]      in_value_2;

  logic             push_1;
  logic             push_2;
  logic [31:0]      push_rank_1;
  logic [31:0]      push_rank_2;
  logic [31:0]      push_value_1;
  logic [31:0]      push_value_2;
  logic [FLOWS-1:0] push_flow_1;
  logic [FLOWS-1:0] push_flow_2;

  logic             sched_pop_valid;

  // Packet source and scheduler side.
  modport master (
    output in_valid_1, in_valid_2, in_flow_1, in_flow_2,
           in_len_1, in_len_2, in_value_1, in_value_2, sched_pop_valid,
    input  in_ready_1, in_ready_2,
           push_1, push_2, push_rank_1, push_rank_2,
           push_value_1, push_value_2, push_flow_1, push_flow_2
  );

  // Ranker side.
  modport slave (
    input  in_valid_1, in_valid_2, in_flow_1, in_flow_2,
           in_len_1, in_len_2, in_value_1, in_value_2, sched_pop_valid,
    output in_ready_1, in_ready_2,
           push_1, push_2, push_rank_1, push_rank_2,
           push_value_1, push_value_2, push_flow_1, push_flow_2
  );
endinterface

// File: rtl/pifo_stfq_ranker.sv
// Start-time fair queuing ranker feeding a two-lane PIFO scheduler.
// Keeps a finish tag and a weight shift per flow plus a virtual clock, ranks
// up to two arrivals per cycle (lane 1 before lane 2), and tracks how many
// entries sit in the scheduler so it is never pushed past SIZE.
module pifo_stfq_ranker #(
  parameter int SIZE  = 10,
  parameter int FLOWS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  pifo_stfq_ranker_if.slave          bus,
  input  logic                       cfg_we,
  input  logic [$clog2(FLOWS)-1:0]   cfg_flow,
  input  logic [3:0]                 cfg_shift,
  output logic [$clog2(SIZE+1)-1:0]  occupancy,
  output logic                       err_flow
);

  localparam int OW = $clog2(SIZE+1);

  logic [OW-1:0] occ;
  logic [OW-1:0] occ_next;
  logic [31:0]   vt;
  logic [31:0]   vt_next;
  logic [31:0]   finish [FLOWS];
  logic [3:0]    shift  [FLOWS];

  logic          ready_1;
  logic          ready_2;
  logic          acc_1;
  logic          acc_2;
  logic          ok_1;
  logic          ok_2;
  logic          any_acc;
  logic          pop_cnt;
  logic          same_flow;

  logic [31:0]   fin_sel_1;
  logic [31:0]   fin_sel_2;
  logic [3:0]    sh_sel_1;
  logic [3:0]    sh_sel_2;
  logic [31:0]   prev_2;
  logic [31:0]   start_1;
  logic [31:0]   start_2;
  logic [31:0]   cost_1;
  logic [31:0]   cost_2;
  logic [31:0]   fin_1;
  logic [31:0]   fin_2;
  logic [31:0]   rank_1;
  logic [31:0]   rank_2;
  logic [31:0]   max_fin;

  logic          push_1_q;
  logic          push_2_q;
  logic [31:0]   push_rank_1_q;
  logic [31:0]   push_rank_2_q;
  logic [31:0]   push_value_1_q;
  logic [31:0]   push_value_2_q;
  logic [FLOWS-1:0] push_flow_1_q;
  logic [FLOWS-1:0] push_flow_2_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Readiness looks only at registered occupancy; lane 2 leaves room for lane 1.
  assign ready_1 = occ < OW'(SIZE);
  assign ready_2 = occ < OW'(SIZE - 1);
  assign acc_1   = bus.in_valid_1 && ready_1;
  assign acc_2   = bus.in_valid_2 && ready_2;
  assign ok_1    = $onehot(bus.in_flow_1);
  assign ok_2    = $onehot(bus.in_flow_2);
  assign any_acc = acc_1 || acc_2;

  // Per-lane lookup of finish tag and shift; the AND-OR mux is exact for one-hot ids.
  always_comb begin
    fin_sel_1 = '0;
    fin_sel_2 = '0;
    sh_sel_1  = '0;
    sh_sel_2  = '0;
    for (int f = 0; f < FLOWS; f++) begin
      if (bus.in_flow_1[f]) begin
        fin_sel_1 = fin_sel_1 | finish[f];
        sh_sel_1  = sh_sel_1  | shift[f];
      end
      if (bus.in_flow_2[f]) begin
        fin_sel_2 = fin_sel_2 | finish[f];
        sh_sel_2  = sh_sel_2  | shift[f];
      end
    end
  end

  // Start/finish tags; lane 2 chains off lane 1 when both carry the same valid flow.
  always_comb begin
    start_1   = max32(vt, fin_sel_1);
    cost_1    = {16'h0000, bus.in_len_1 >> sh_sel_1};
    fin_1     = sat_add(start_1, cost_1);
    same_flow = acc_1 && ok_1 && (bus.in_flow_1 == bus.in_flow_2);
    prev_2    = same_flow ? fin_1 : fin_sel_2;
    start_2   = max32(vt, prev_2);
    cost_2    = {16'h0000, bus.in_len_2 >> sh_sel_2};
    fin_2     = sat_add(start_2, cost_2);
    rank_1    = ok_1 ? start_1 : vt;
    rank_2    = ok_2 ? start_2 : vt;
  end

  // Largest finish tag, used to fast-forward the virtual clock when the queue drains.
  always_comb begin
    max_fin = '0;
    for (int f = 0; f < FLOWS; f++) begin
      if (finish[f] > max_fin) max_fin = finish[f];
    end
  end

  // Occupancy and virtual clock next values; pops on an empty scheduler are ignored.
  always_comb begin
    pop_cnt  = bus.sched_pop_valid && (occ != '0);
    occ_next = occ + OW'(acc_1) + OW'(acc_2) - OW'(pop_cnt);
    vt_next  = pop_cnt ? sat_add(vt, 32'd1) : vt;
    if ((occ_next == '0) && !any_acc) vt_next = max_fin;
  end

  // Push lanes, error pulse, occupancy and virtual clock registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ            <= '0;
      vt             <= '0;
      err_flow       <= 1'b0;
      push_1_q       <= 1'b0;
      push_2_q       <= 1'b0;
      push_rank_1_q  <= '0;
      push_rank_2_q  <= '0;
      push_value_1_q <= '0;
      push_value_2_q <= '0;
      push_flow_1_q  <= '0;
      push_flow_2_q  <= '0;
    end else begin
      occ            <= occ_next;
      vt             <= vt_next;
      err_flow       <= (acc_1 && !ok_1) || (acc_2 && !ok_2);
      push_1_q       <= acc_1;
      push_2_q       <= acc_2;
      push_rank_1_q  <= rank_1;
      push_rank_2_q  <= rank_2;
      push_value_1_q <= bus.in_value_1;
      push_value_2_q <= bus.in_value_2;
      push_flow_1_q  <= bus.in_flow_1;
      push_flow_2_q  <= bus.in_flow_2;
    end
  end

  // Per-flow finish tags and weight shifts; lane 2 wins since it already includes lane 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < FLOWS; f++) begin
        finish[f] <= '0;
        shift[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        if (acc_2 && ok_2 && bus.in_flow_2[f]) begin
          finish[f] <= fin_2;
        end else if (acc_1 && ok_1 && bus.in_flow_1[f]) begin
          finish[f] <= fin_1;
        end
        if (cfg_we && (int'(cfg_flow) == f)) shift[f] <= cfg_shift;
      end
    end
  end

  assign bus.in_ready_1   = ready_1;
  assign bus.in_ready_2   = ready_2;
  assign bus.push_1       = push_1_q;
  assign bus.push_2       = push_2_q;
  assign bus.push_rank_1  = push_rank_1_q;
  assign bus.push_rank_2  = push_rank_2_q;
  assign bus.push_value_1 = push_value_1_q;
  assign bus.push_value_2 = push_value_2_q;
  assign bus.push_flow_1  = push_flow_1_q;
  assign bus.push_flow_2  = push_flow_2_q;
  assign occupancy        = occ;

endmodule

// File: tb/tb_pifo_stfq_ranker.sv
// Bench for the STFQ ranker: directed vector table for the documented
// scenarios, then random traffic against a sequential reference model.
module tb_pifo_stfq_ranker;
  localparam int SIZE  = 4;
  localparam int FLOWS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we;
  logic [1:0] cfg_flow;
  logic [3:0] cfg_shift;
  logic [2:0] occupancy;
  logic       err_flow;

  pifo_stfq_ranker_if #(.FLOWS(FLOWS)) bus ();

  pifo_stfq_ranker #(.SIZE(SIZE), .FLOWS(FLOWS)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_shift(cfg_shift),
    .occupancy(occupancy), .err_flow(err_flow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rb; bit v1; logic [3:0] f1; logic [15:0] l1;
    bit v2; logic [3:0] f2; logic [15:0] l2;
    bit pop; bit we; logic [1:0] cf; logic [3:0] cs;
    bit r1; bit r2; bit p1; int k1; bit p2; int k2; int occ; bit err;
  } vec_t;
  vec_t tv[$];

  task automatic set_in(input bit v1, input logic [3:0] f1, input logic [15:0] l1, input logic [31:0] d1,
                        input bit v2, input logic [3:0] f2, input logic [15:0] l2, input logic [31:0] d2,
                        input bit pop, input bit we, input logic [1:0] cf, input logic [3:0] cs);
    bus.in_valid_1 = v1; bus.in_flow_1 = f1; bus.in_len_1 = l1; bus.in_value_1 = d1;
    bus.in_valid_2 = v2; bus.in_flow_2 = f2; bus.in_len_2 = l2; bus.in_value_2 = d2;
    bus.sched_pop_valid = pop;
    cfg_we = we; cfg_flow = cf; cfg_shift = cs;
  endtask

  // Reset for two cycles with lane 1 asserting valid; nothing may be pushed.
  task automatic do_reset();
    rst = 1'b0;
    set_in(1, 4'b0001, 16'd9, 32'h1, 1, 4'b0010, 16'd9, 32'h2, 1, 0, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst push_1", bus.push_1, 0);
      chk("rst push_2", bus.push_2, 0);
      chk("rst occupancy", occupancy, 0);
      chk("rst err_flow", err_flow, 0);
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst in_ready_1", bus.in_ready_1, 1);
    chk("rst in_ready_2", bus.in_ready_2, 1);
  endtask

  // Reference model: lanes processed one after the other with plain arithmetic.
  longint fin_m [FLOWS];
  int     sh_m  [FLOWS];
  longint vt_m;
  int     occ_m;

  function automatic longint sat(input longint x);
    return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < FLOWS; k++) begin fin_m[k] = 0; sh_m[k] = 0; end
    vt_m = 0; occ_m = 0;
  endtask

  task automatic model_lane(input logic [3:0] f, input logic [15:0] l, output longint rank, output bit bad);
    bad  = ($countones(f) != 1);
    rank = vt_m;
    if (!bad) begin
      for (int k = 0; k < FLOWS; k++) begin
        if (f[k]) begin
          rank     = (vt_m > fin_m[k]) ? vt_m : fin_m[k];
          fin_m[k] = sat(rank + longint'(l >> sh_m[k]));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rb v1 f1      l1   v2 f2      l2  pop we cf cs   r1 r2 p1 k1   p2 k2  occ err
    tv.push_back('{1, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 0, 0,   0, 0,  0, 0});
    tv.push_back('{0, 1, 4'b0001, 100, 0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 0,   0, 0,  1, 0});
    tv.push_back('{0, 1, 4'b0001, 50,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 100, 0, 0,  2, 0});
    tv.push_back('{0, 1, 4'b0001, 25,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 150, 0, 0,  3, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 0, 0, 0,   0, 0,  2, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 0, 0,   0, 0,  1, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 0, 0,   0, 0,  0, 0});
    tv.push_back('{0, 1, 4'b0100, 5,   0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 175, 0, 0,  1, 0});
    // dual lane, same flow
    tv.push_back('{1, 1, 4'b0010, 40,  1, 4'b0010, 60, 0,  0, 0, 0,  1, 1, 1, 0,   1, 40, 2, 0});
    tv.push_back('{0, 1, 4'b0010, 8,   0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 100, 0, 0,  3, 0});
    // weights
    tv.push_back('{1, 0, 4'b0000, 0,   0, 4'b0000, 0,  0,  1, 1, 2,  1, 1, 0, 0,   0, 0,  0, 0});
    tv.push_back('{0, 1, 4'b0010, 64,  1, 4'b0001, 64, 0,  0, 0, 0,  1, 1, 1, 0,   1, 0,  2, 0});
    tv.push_back('{0, 1, 4'b0010, 64,  1, 4'b0001, 64, 0,  0, 0, 0,  1, 1, 1, 16,  1, 64, 4, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  1, 0, 1,  0, 0, 0, 0,   0, 0,  3, 0});
    tv.push_back('{0, 1, 4'b0001, 10,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 0, 1, 128, 0, 0,  4, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  0, 0, 0, 0,   0, 0,  3, 0});
    tv.push_back('{0, 1, 4'b0001, 0,   0, 4'b0000, 0,  0,  0, 0, 0,  1, 0, 1, 133, 0, 0,  4, 0});
    // full / backpressure / lane independence
    tv.push_back('{1, 1, 4'b0001, 1,   1, 4'b0010, 1,  0,  0, 0, 0,  1, 1, 1, 0,   1, 0,  2, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   1, 4'b0100, 7,  0,  0, 0, 0,  1, 1, 0, 0,   1, 0,  3, 0});
    tv.push_back('{0, 1, 4'b0001, 1,   1, 4'b0010, 1,  0,  0, 0, 0,  1, 0, 1, 1,   0, 0,  4, 0});
    tv.push_back('{0, 1, 4'b0100, 1,   1, 4'b0100, 1,  1,  0, 0, 0,  0, 0, 0, 0,   0, 0,  3, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   1, 4'b1000, 3,  0,  0, 0, 0,  1, 0, 0, 0,   0, 0,  3, 0});
    tv.push_back('{0, 1, 4'b1000, 3,   0, 4'b0000, 0,  0,  0, 0, 0,  1, 0, 1, 1,   0, 0,  4, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  0, 0, 0, 0,   0, 0,  3, 0});
    tv.push_back('{0, 1, 4'b0001, 4,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 0, 1, 2,   0, 0,  3, 0});
    // bad flow ids and idle fast-forward
    tv.push_back('{1, 1, 4'b0001, 30,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 0,   0, 0,  1, 0});
    tv.push_back('{0, 1, 4'b0000, 10,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 0,   0, 0,  2, 1});
    tv.push_back('{0, 1, 4'b0011, 10,  0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 1, 0,   0, 0,  2, 1});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 0, 0,   0, 0,  1, 0});
    tv.push_back('{0, 0, 4'b0000, 0,   0, 4'b0000, 0,  1,  0, 0, 0,  1, 1, 0, 0,   0, 0,  0, 0});
    tv.push_back('{0, 1, 4'b0000, 10,  0, 4'b0000, 0,  0,  0, 0, 0,  1, 1, 1, 30,  0, 0,  1, 1});
    tv.push_back('{0, 0, 4'b0000, 0,   1, 4'b0001, 0,  0,  0, 0, 0,  1, 1, 0, 0,   1, 30, 2, 0});
    tv.push_back('{0, 1, 4'b0010, 4,   1, 4'b0101, 9,  0,  0, 0, 0,  1, 1, 1, 30,  1, 30, 4, 1});

    foreach (tv[i]) begin
      logic [31:0] d1, d2;
      if (tv[i].rb) do_reset();
      d1 = 32'hA500_0000 | 32'(i);
      d2 = 32'h5A00_0000 | 32'(i);
      set_in(tv[i].v1, tv[i].f1, tv[i].l1, d1, tv[i].v2, tv[i].f2, tv[i].l2, d2,
             tv[i].pop, tv[i].we, tv[i].cf, tv[i].cs);
      #0;
      chk($sformatf("v%0d in_ready_1", i), bus.in_ready_1, tv[i].r1);
      chk($sformatf("v%0d in_ready_2", i), bus.in_ready_2, tv[i].r2);
      @(posedge clk); #1;
      chk($sformatf("v%0d push_1", i), bus.push_1, tv[i].p1);
      chk($sformatf("v%0d push_2", i), bus.push_2, tv[i].p2);
      if (tv[i].p1) begin
        chk($sformatf("v%0d push_rank_1", i), bus.push_rank_1, tv[i].k1);
        chk($sformatf("v%0d push_value_1", i), bus.push_value_1, d1);
        chk($sformatf("v%0d push_flow_1", i), 32'(bus.push_flow_1), 32'(tv[i].f1));
      end
      if (tv[i].p2) begin
        chk($sformatf("v%0d push_rank_2", i), bus.push_rank_2, tv[i].k2);
        chk($sformatf("v%0d push_value_2", i), bus.push_value_2, d2);
        chk($sformatf("v%0d push_flow_2", i), 32'(bus.push_flow_2), 32'(tv[i].f2));
      end
      chk($sformatf("v%0d occupancy", i), occupancy, tv[i].occ);
      chk($sformatf("v%0d err_flow", i), err_flow, tv[i].err);
    end

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit v1, v2, pop, we, a1, a2, b1, b2, pc;
      logic [3:0] f1, f2, cs;
      logic [1:0] cf;
      logic [15:0] l1, l2;
      logic [31:0] d1, d2;
      longint k1, k2, mx;
      int sel;
      v1 = ($urandom_range(3) != 0);
      v2 = ($urandom_range(2) != 0);
      sel = $urandom_range(7);
      f1 = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      sel = $urandom_range(7);
      f2 = (sel == 0) ? 4'b0000 : (sel == 1) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      l1 = ($urandom_range(15) == 0) ? 16'($urandom) : 16'($urandom_range(300));
      l2 = ($urandom_range(15) == 0) ? 16'($urandom) : 16'($urandom_range(300));
      d1 = $urandom; d2 = $urandom;
      pop = ($urandom_range(1) == 1);
      we  = ($urandom_range(15) == 0);
      cf  = 2'($urandom);
      cs  = 4'($urandom_range(4));
      set_in(v1, f1, l1, d1, v2, f2, l2, d2, pop, we, cf, cs);
      #0;
      chk("rnd in_ready_1", bus.in_ready_1, (occ_m < SIZE) ? 1 : 0);
      chk("rnd in_ready_2", bus.in_ready_2, (occ_m < SIZE - 1) ? 1 : 0);

      a1 = v1 && (occ_m < SIZE);
      a2 = v2 && (occ_m < SIZE - 1);
      k1 = 0; k2 = 0; b1 = 0; b2 = 0;
      if (a1) model_lane(f1, l1, k1, b1);
      if (a2) model_lane(f2, l2, k2, b2);
      pc = pop && (occ_m != 0);
      occ_m = occ_m + int'(a1) + int'(a2) - int'(pc);
      if (pc) vt_m = sat(vt_m + 1);
      if (occ_m == 0 && !a1 && !a2) begin
        mx = 0;
        for (int k = 0; k < FLOWS; k++) if (fin_m[k] > mx) mx = fin_m[k];
        vt_m = mx;
      end
      if (we && int'(cf) < FLOWS) sh_m[cf] = int'(cs);

      @(posedge clk); #1;
      chk("rnd push_1", bus.push_1, a1);
      chk("rnd push_2", bus.push_2, a2);
      if (a1) begin
        chk("rnd push_rank_1", bus.push_rank_1, k1[31:0]);
        chk("rnd push_value_1", bus.push_value_1, d1);
        chk("rnd push_flow_1", 32'(bus.push_flow_1), 32'(f1));
      end
      if (a2) begin
        chk("rnd push_rank_2", bus.push_rank_2, k2[31:0]);
        chk("rnd push_value_2", bus.push_value_2, d2);
        chk("rnd push_flow_2", 32'(bus.push_flow_2), 32'(f2));
      end
      chk("rnd occupancy", occupancy, occ_m);
      chk("rnd err_flow", err_flow, (a1 && b1) || (a2 && b2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
